// File: rtl/fu_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// fu_ctrl_pkg
// Shared definitions for the functional-unit controllers that use the
// ce/idle/done/result handshake.
//   - State encoding of the issue FSM (S_IDLE / S_ISSUE / S_WAIT).
//   - Default watchdog limit.
//   - Helper for the one-entry writeback slot.
// -----------------------------------------------------------------------------
package fu_ctrl_pkg;

    localparam logic [1:0] ST_IDLE_ENC  = 2'd0;
    localparam logic [1:0] ST_ISSUE_ENC = 2'd1;
    localparam logic [1:0] ST_WAIT_ENC  = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE  = ST_IDLE_ENC,
        S_ISSUE = ST_ISSUE_ENC,
        S_WAIT  = ST_WAIT_ENC
    } fu_state_t;

    localparam int unsigned FU_DEFAULT_TIMEOUT = 64;

    // A one-entry writeback slot can take a new op when it is empty or
    // is being drained in the same cycle.
    function automatic logic wb_slot_free(input logic valid, input logic ready);
        return (~valid) | ready;
    endfunction

endpackage

// File: rtl/fu_watchdog.sv
// -----------------------------------------------------------------------------
// fu_watchdog
// Saturating cycle counter that flags a functional unit that fails to answer.
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   clr       : restart the count at zero (has priority over en)
//   en        : count this cycle
//   count     : current count, saturates at TIMEOUT
//   expired   : this counting cycle is the last one allowed (count is
//               about to step onto TIMEOUT)
// -----------------------------------------------------------------------------
module fu_watchdog
    import fu_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT = FU_DEFAULT_TIMEOUT,
    localparam int unsigned CW = $clog2(TIMEOUT + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          en,
    output logic [CW-1:0] count,
    output logic          expired
);

    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT);

    logic [CW-1:0] r_count;

    // Saturating counter: cleared by clr, advanced by en, held at LIMIT.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (clr) begin
            r_count <= '0;
        end else if (en && (r_count != LIMIT)) begin
            r_count <= r_count + CW'(1);
        end else begin
            r_count <= r_count;
        end
    end

    assign count   = r_count;
    assign expired = en & ~clr & (r_count >= (LIMIT - CW'(1)));

endmodule

// File: rtl/fu_issue_ctrl.sv
// -----------------------------------------------------------------------------
// fu_issue_ctrl
// Issue-side controller for a single-operation functional unit. Accepts one op
// from dispatch, registers its operands toward the unit, pulses fu_ce, waits
// for fu_done and captures the result with its tag in a one-entry writeback
// register. A watchdog abandons an op whose unit never answers and raises a
// sticky error.
// Ports:
//   clk, rst                      : clock, synchronous active-high reset
//   in_valid/in_ready             : dispatch handshake (in_ready is combinational)
//   in_data_0/1, in_tag           : operands and destination tag
//   fu_ce                         : one-cycle start pulse to the unit
//   fu_idle, fu_done, fu_result   : unit status and result
//   fu_data_0/1                   : registered operands, held until next accept
//   wb_valid/wb_ready             : writeback handshake
//   wb_result, wb_tag             : captured result and its tag
//   busy                          : op in flight or writeback entry held
//   err_timeout                   : sticky watchdog error, cleared by rst only
// -----------------------------------------------------------------------------
module fu_issue_ctrl
    import fu_ctrl_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned TAG_WIDTH  = 4,
    parameter int unsigned TIMEOUT    = FU_DEFAULT_TIMEOUT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data_0,
    input  logic [DATA_WIDTH-1:0] in_data_1,
    input  logic [TAG_WIDTH-1:0]  in_tag,
    output logic                  fu_ce,
    input  logic                  fu_idle,
    output logic [DATA_WIDTH-1:0] fu_data_0,
    output logic [DATA_WIDTH-1:0] fu_data_1,
    input  logic [DATA_WIDTH-1:0] fu_result,
    input  logic                  fu_done,
    output logic                  wb_valid,
    input  logic                  wb_ready,
    output logic [DATA_WIDTH-1:0] wb_result,
    output logic [TAG_WIDTH-1:0]  wb_tag,
    output logic                  busy,
    output logic                  err_timeout
);

    localparam int unsigned        WD_W   = $clog2(TIMEOUT + 1);
    localparam logic [WD_W-1:0]    WD_SAT = WD_W'(TIMEOUT);

    fu_state_t             r_state;
    logic                  r_fu_ce;
    logic [DATA_WIDTH-1:0] r_fu_data_0;
    logic [DATA_WIDTH-1:0] r_fu_data_1;
    logic [TAG_WIDTH-1:0]  r_tag;
    logic                  r_wb_valid;
    logic [DATA_WIDTH-1:0] r_wb_result;
    logic [TAG_WIDTH-1:0]  r_wb_tag;
    logic                  r_err_timeout;

    logic                  w_in_ready;
    logic                  w_accept;
    logic                  w_wb_clear;
    logic [WD_W-1:0]       w_wd_count;
    logic                  w_wd_expired;
    logic                  w_timeout;

    assign w_in_ready = (r_state == S_IDLE) & fu_idle
                      & wb_slot_free(r_wb_valid, wb_ready) & ~rst;
    assign w_accept   = in_valid & w_in_ready;
    assign w_wb_clear = r_wb_valid & wb_ready;

    // The count is restarted as the op is accepted, so it reads zero in the
    // ce cycle and k in the k-th cycle after it. Expiry therefore lands in
    // cycle TIMEOUT-1 after ce and err_timeout shows TIMEOUT cycles after ce.
    fu_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk     (clk),
        .rst     (rst),
        .clr     (w_accept),
        .en      (r_state != S_IDLE),
        .count   (w_wd_count),
        .expired (w_wd_expired)
    );

    // A count parked at saturation while still waiting is treated as expired
    // as well, so a missed expiry cycle can never leave the FSM stuck.
    assign w_timeout = w_wd_expired | (w_wd_count == WD_SAT);

    // Issue FSM with all outputs registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_fu_ce       <= 1'b0;
            r_fu_data_0   <= '0;
            r_fu_data_1   <= '0;
            r_tag         <= '0;
            r_wb_valid    <= 1'b0;
            r_wb_result   <= '0;
            r_wb_tag      <= '0;
            r_err_timeout <= 1'b0;
        end else begin
            r_fu_ce <= 1'b0;
            if (w_wb_clear) begin
                r_wb_valid <= 1'b0;
            end
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_fu_data_0 <= in_data_0;
                        r_fu_data_1 <= in_data_1;
                        r_tag       <= in_tag;
                        r_fu_ce     <= 1'b1;
                        r_state     <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    // fu_done here is stale (e.g. the unit's post-reset pulse).
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    if (fu_done) begin
                        r_wb_result <= fu_result;
                        r_wb_tag    <= r_tag;
                        r_wb_valid  <= 1'b1;
                        r_state     <= S_IDLE;
                    end else if (w_timeout) begin
                        r_err_timeout <= 1'b1;
                        r_state       <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign in_ready    = w_in_ready;
    assign fu_ce       = r_fu_ce;
    assign fu_data_0   = r_fu_data_0;
    assign fu_data_1   = r_fu_data_1;
    assign wb_valid    = r_wb_valid;
    assign wb_result   = r_wb_result;
    assign wb_tag      = r_wb_tag;
    assign busy        = (r_state != S_IDLE) | r_wb_valid;
    assign err_timeout = r_err_timeout;

endmodule

// File: tb/tb_fu_issue_ctrl.sv
// -----------------------------------------------------------------------------
// tb_fu_issue_ctrl
// Directed and randomized bench for fu_issue_ctrl with a subtracting unit
// (result = data_1 - data_0) of programmable latency, TIMEOUT = 8.
// Expected outputs come from a transaction-level model: an op in flight is
// described by the cycle its ce is due, and the writeback slot is a queue.
// -----------------------------------------------------------------------------
module tb_fu_issue_ctrl;

    localparam int DW = 32;
    localparam int TW = 4;
    localparam int TO = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data_0;
    logic [DW-1:0] in_data_1;
    logic [TW-1:0] in_tag;
    logic          fu_ce;
    logic          fu_idle;
    logic [DW-1:0] fu_data_0;
    logic [DW-1:0] fu_data_1;
    logic [DW-1:0] fu_result;
    logic          fu_done;
    logic          wb_valid;
    logic          wb_ready;
    logic [DW-1:0] wb_result;
    logic [TW-1:0] wb_tag;
    logic          busy;
    logic          err_timeout;

    always #5 clk = ~clk;

    fu_issue_ctrl #(
        .DATA_WIDTH (DW),
        .TAG_WIDTH  (TW),
        .TIMEOUT    (TO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data_0   (in_data_0),
        .in_data_1   (in_data_1),
        .in_tag      (in_tag),
        .fu_ce       (fu_ce),
        .fu_idle     (fu_idle),
        .fu_data_0   (fu_data_0),
        .fu_data_1   (fu_data_1),
        .fu_result   (fu_result),
        .fu_done     (fu_done),
        .wb_valid    (wb_valid),
        .wb_ready    (wb_ready),
        .wb_result   (wb_result),
        .wb_tag      (wb_tag),
        .busy        (busy),
        .err_timeout (err_timeout)
    );

    int n_pass   = 0;
    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // reference model
    bit            m_inflight;
    int            m_ce_cyc;
    logic [DW-1:0] m_d0, m_d1;
    logic [TW-1:0] m_tag;
    logic [DW-1:0] m_wb_res[$];
    logic [TW-1:0] m_wb_tag[$];
    bit            m_err;

    // unit environment
    bit            u_active;
    int            u_done_cyc;
    logic [DW-1:0] u_res;
    int            u_lat;   // -1: never answers
    bit            u_spur;

    task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", name, obs, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_inflight = 1'b0;
        m_ce_cyc   = -10;
        m_d0       = '0;
        m_d1       = '0;
        m_tag      = '0;
        m_wb_res.delete();
        m_wb_tag.delete();
        m_err      = 1'b0;
    endtask

    // One clock cycle: drive inputs, check outputs against the model, advance.
    task automatic tick(input bit r, input bit v, input logic [DW-1:0] d0,
                        input logic [DW-1:0] d1, input logic [TW-1:0] tg, input bit wbr);
        bit done_now;
        bit exp_ready;
        bit exp_ce;
        rst       = r;
        in_valid  = v;
        in_data_0 = d0;
        in_data_1 = d1;
        in_tag    = tg;
        wb_ready  = wbr;
        done_now  = (u_active && (cyc == u_done_cyc)) || u_spur;
        fu_done   = done_now;
        fu_result = done_now ? u_res : DW'($urandom);
        fu_idle   = !u_active && !fu_ce;
        #1;
        exp_ce    = m_inflight && (cyc == m_ce_cyc);
        exp_ready = !r && !m_inflight && fu_idle && ((m_wb_res.size() == 0) || wbr);
        check("fu_ce", fu_ce, exp_ce);
        check("fu_data_0", fu_data_0, m_d0);
        check("fu_data_1", fu_data_1, m_d1);
        check("wb_valid", wb_valid, m_wb_res.size() != 0);
        if (m_wb_res.size() != 0) begin
            check("wb_result", wb_result, m_wb_res[0]);
            check("wb_tag", wb_tag, m_wb_tag[0]);
        end
        check("busy", busy, m_inflight || (m_wb_res.size() != 0));
        check("err_timeout", err_timeout, m_err);
        check("in_ready", in_ready, exp_ready);
        if (r) begin
            model_reset();
        end else begin
            if ((m_wb_res.size() != 0) && wbr) begin
                void'(m_wb_res.pop_front());
                void'(m_wb_tag.pop_front());
            end
            if (m_inflight && (cyc > m_ce_cyc)) begin
                if (done_now) begin
                    m_wb_res.push_back(fu_result);
                    m_wb_tag.push_back(m_tag);
                    m_inflight = 1'b0;
                end else if ((cyc - m_ce_cyc) >= (TO - 1)) begin
                    m_err      = 1'b1;
                    m_inflight = 1'b0;
                end
            end
            if (exp_ready && v) begin
                m_inflight = 1'b1;
                m_ce_cyc   = cyc + 1;
                m_d0       = d0;
                m_d1       = d1;
                m_tag      = tg;
            end
        end
        if (r) begin
            u_active = 1'b0;
        end else begin
            if (done_now) u_active = 1'b0;
            if (fu_ce) begin
                u_active   = 1'b1;
                u_res      = fu_data_1 - fu_data_0;
                u_done_cyc = (u_lat < 0) ? -1 : (cyc + 1 + u_lat);
            end
        end
        u_spur = 1'b0;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle_ticks(input int n, input bit wbr);
        for (int i = 0; i < n; i++) tick(1'b0, 1'b0, '0, '0, '0, wbr);
    endtask

    initial begin
        u_active = 1'b0; u_done_cyc = -1; u_res = '0; u_lat = 3; u_spur = 1'b0;
        rst = 1'b1; in_valid = 1'b0; in_data_0 = '0; in_data_1 = '0; in_tag = '0;
        wb_ready = 1'b0; fu_idle = 1'b1; fu_done = 1'b0; fu_result = '0;
        repeat (2) @(posedge clk);
        #1;
        model_reset();

        // reset values
        check("rst_wb_result", wb_result, 32'd0);
        check("rst_wb_tag", wb_tag, 4'd0);
        tick(1'b1, 1'b0, '0, '0, '0, 1'b0);

        // spurious done while idle is ignored
        u_spur = 1'b1;
        tick(1'b0, 1'b0, '0, '0, '0, 1'b1);
        check("spur_wb_valid", wb_valid, 1'b0);
        check("spur_busy", busy, 1'b0);

        // first op: 12 - 5 with latency 3, ce one cycle after accept
        u_lat = 3;
        tick(1'b0, 1'b1, 32'd5, 32'd12, 4'd3, 1'b0);
        check("op1_ce", fu_ce, 1'b1);
        idle_ticks(5, 1'b0);
        check("op1_wb_valid", wb_valid, 1'b1);
        check("op1_wb_result", wb_result, 32'd7);
        check("op1_wb_tag", wb_tag, 4'd3);

        // backpressure: second op offered while the entry is held
        u_lat = 2;
        for (int i = 0; i < 10; i++) tick(1'b0, 1'b1, 32'd100, 32'd250, 4'd9, 1'b0);
        check("bp_wb_result", wb_result, 32'd7);
        check("bp_ce_idle", fu_ce, 1'b0);
        tick(1'b0, 1'b1, 32'd100, 32'd250, 4'd9, 1'b1);
        check("op2_ce", fu_ce, 1'b1);
        check("op2_data_0", fu_data_0, 32'd100);
        idle_ticks(5, 1'b0);
        check("op2_wb_result", wb_result, 32'd150);
        check("op2_wb_tag", wb_tag, 4'd9);
        idle_ticks(1, 1'b1);

        // done lands in the last allowed cycle: done wins
        u_lat = TO - 2;
        tick(1'b0, 1'b1, 32'd1, 32'd41, 4'd6, 1'b1);
        idle_ticks(TO, 1'b0);
        check("coin_wb_valid", wb_valid, 1'b1);
        check("coin_wb_result", wb_result, 32'd40);
        check("coin_err", err_timeout, 1'b0);
        idle_ticks(1, 1'b1);

        // unit that never answers
        u_lat = -1;
        tick(1'b0, 1'b1, 32'd2, 32'd3, 4'd1, 1'b1);
        idle_ticks(TO - 1, 1'b1);
        check("to_err_early", err_timeout, 1'b0);
        idle_ticks(1, 1'b1);
        check("to_err", err_timeout, 1'b1);
        check("to_wb_valid", wb_valid, 1'b0);
        check("to_busy", busy, 1'b0);
        u_lat = 3;
        for (int i = 0; i < 3; i++) tick(1'b0, 1'b1, 32'd9, 32'd9, 4'd2, 1'b1);
        u_active = 1'b0;
        tick(1'b0, 1'b0, '0, '0, '0, 1'b1);
        check("to_err_sticky", err_timeout, 1'b1);

        // reset while waiting
        tick(1'b0, 1'b1, 32'd10, 32'd20, 4'd4, 1'b1);
        idle_ticks(3, 1'b1);
        tick(1'b1, 1'b0, '0, '0, '0, 1'b1);
        check("rw_busy", busy, 1'b0);
        check("rw_err", err_timeout, 1'b0);
        check("rw_data_1", fu_data_1, 32'd0);

        // reset while the writeback entry is held
        u_lat = 0;
        tick(1'b0, 1'b1, 32'd3, 32'd8, 4'd7, 1'b0);
        idle_ticks(2, 1'b0);
        check("rv_wb_valid_pre", wb_valid, 1'b1);
        tick(1'b1, 1'b0, '0, '0, '0, 1'b0);
        check("rv_wb_valid", wb_valid, 1'b0);
        check("rv_wb_result", wb_result, 32'd0);

        // fresh op after reset
        u_lat = 1;
        tick(1'b0, 1'b1, 32'd7, 32'd30, 4'd5, 1'b1);
        idle_ticks(4, 1'b0);
        check("fresh_wb_result", wb_result, 32'd23);
        check("fresh_wb_tag", wb_tag, 4'd5);
        idle_ticks(1, 1'b1);

        // randomized traffic, latencies past the limit included
        for (int i = 0; i < 800; i++) begin
            u_lat  = $urandom_range(0, TO + 1);
            u_spur = !u_active && ($urandom_range(0, 19) == 0);
            tick($urandom_range(0, 149) == 0, $urandom_range(0, 1) == 1,
                 DW'($urandom), DW'($urandom), TW'($urandom),
                 $urandom_range(0, 3) != 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
